// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with start/busy/done handshake; shift-add multiply and restoring
// divide iterate one bit per clock. Define ALU_SEQ_SIGNED_EN for two's complement operands.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         command_code,
  input  logic [WIDTH-1:0]   xdata,
  input  logic [WIDTH-1:0]   ydata,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               flagZ,
  output logic               flagO,
  output logic               flagN
);
  localparam int W2    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_NOT  = 3'd7;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] xmag, ymag;
  logic             div_ovf;

  logic [W2-1:0]    acc, mcand, acc_nxt;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] rem, quot, dvsr, rem_nxt, quot_nxt, diff;
  logic [WIDTH:0]   shifted;
  logic             ge;

  logic [W2-1:0]    mul_res, div_res, single_res;
  logic             mul_n, div_n, single_o, single_n;

`ifdef ALU_SEQ_SIGNED_EN
  logic neg_q_r, neg_r_r;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [W2-1:0] apply_sign2(input logic [W2-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic signed [W2-1:0] sext(input logic [WIDTH-1:0] v);
    return {{WIDTH{v[WIDTH-1]}}, v};
  endfunction

  assign xmag    = magnitude(xdata);
  assign ymag    = magnitude(ydata);
  assign div_ovf = (xdata == {1'b1, {(WIDTH-1){1'b0}}}) && (ydata == '1);
  assign mul_res = apply_sign2(acc_nxt, neg_q_r);
  assign div_res = {apply_sign(rem_nxt, neg_r_r), apply_sign(quot_nxt, neg_q_r)};
  assign mul_n   = mul_res[W2-1];
  assign div_n   = div_res[WIDTH-1];

  // Quotient/product sign from operand signs; remainder follows X.
  always_ff @(posedge clock) begin
    if (state == IDLE && start) begin
      neg_q_r <= xdata[WIDTH-1] ^ ydata[WIDTH-1];
      neg_r_r <= xdata[WIDTH-1];
    end
  end
`else
  assign xmag    = xdata;
  assign ymag    = ydata;
  assign div_ovf = 1'b0;
  assign mul_res = acc_nxt;
  assign div_res = {rem_nxt, quot_nxt};
  assign mul_n   = 1'b0;
  assign div_n   = 1'b0;
`endif

  always_comb begin
    single_res = '0;
    single_o   = 1'b0;
    single_n   = 1'b0;
    case (command_code)
      OP_PASS: single_res = {{WIDTH{1'b0}}, xdata};
`ifdef ALU_SEQ_SIGNED_EN
      OP_ADD: begin
        single_res = sext(xdata) + sext(ydata);
        single_n   = single_res[W2-1];
      end
      OP_SUB: begin
        single_res = sext(xdata) - sext(ydata);
        single_n   = single_res[W2-1];
      end
`else
      OP_ADD: single_res = {{WIDTH{1'b0}}, xdata} + {{WIDTH{1'b0}}, ydata};
      OP_SUB: begin
        single_res = {{WIDTH{1'b0}}, ((xdata < ydata) ? ydata - xdata : xdata - ydata)};
        single_n   = (xdata < ydata);
      end
`endif
      OP_DIV:  single_o   = 1'b1;  // only taken here for a zero divisor or signed overflow
      OP_AND:  single_res = {{WIDTH{1'b0}}, xdata & ydata};
      OP_OR:   single_res = {{WIDTH{1'b0}}, xdata | ydata};
      OP_NOT:  single_res = {{WIDTH{1'b0}}, ~xdata};
      default: single_res = '0;
    endcase
  end

  assign acc_nxt  = mplier[0] ? acc + mcand : acc;
  assign shifted  = {rem, quot[WIDTH-1]};
  assign ge       = shifted >= {1'b0, dvsr};
  assign diff     = shifted[WIDTH-1:0] - dvsr;
  assign rem_nxt  = ge ? diff : shifted[WIDTH-1:0];
  assign quot_nxt = {quot[WIDTH-2:0], ge};

  // Iteration registers: loaded on acceptance, then shifted once per clock.
  always_ff @(posedge clock) begin
    if (state == IDLE) begin
      if (start) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, xmag};
        mplier <= ymag;
        rem    <= '0;
        quot   <= xmag;
        dvsr   <= ymag;
      end
    end else begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      rem    <= rem_nxt;
      quot   <= quot_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      flagZ  <= 1'b0;
      flagO  <= 1'b0;
      flagN  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
            if (command_code == OP_MUL) begin
              state <= MUL;
              busy  <= 1'b1;
            end else if (command_code == OP_DIV && ydata != '0 && !div_ovf) begin
              state <= DIV;
              busy  <= 1'b1;
            end else begin
              done   <= 1'b1;
              result <= single_res;
              flagZ  <= (single_res == '0);
              flagO  <= single_o;
              flagN  <= single_n;
            end
          end
        end
        MUL: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= mul_res;
            flagZ  <= (mul_res == '0);
            flagO  <= 1'b0;
            flagN  <= mul_n;
          end
        end
        DIV: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= div_res;
            flagZ  <= (div_res == '0);
            flagO  <= 1'b0;
            flagN  <= div_n;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed and randomized operations against an
// arithmetic reference model, plus handshake, back-to-back and mid-iteration reset cases.
module tb_alu_seq;
  localparam int W = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic [2:0]     command_code;
  logic [W-1:0]   xdata, ydata;
  logic           busy, done;
  logic [2*W-1:0] result;
  logic           flagZ, flagO, flagN;

  int checks   = 0;
  int failures = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .command_code(command_code),
    .xdata(xdata), .ydata(ydata), .busy(busy), .done(done), .result(result),
    .flagZ(flagZ), .flagO(flagO), .flagN(flagN)
  );

  always #5 clock = ~clock;

  logic [2:0]   dc [8] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd4};
  logic [W-1:0] dx [8] = '{4'd9, 4'd3, 4'd5, 4'd15, 4'd13, 4'd7, 4'hD, 4'h9};
  logic [W-1:0] dy [8] = '{4'd8, 4'd5, 4'd5, 4'd15, 4'd4, 4'd0, 4'd5, 4'd2};

  function automatic void model(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [2*W-1:0] r, output logic z, output logic o,
                                output logic n, output logic multi);
    longint ux, uy, sx, sy, t, q, rm;
    ux = x; uy = y;
    sx = ux; sy = uy;
`ifdef ALU_SEQ_SIGNED_EN
    if (x[W-1]) sx = ux - (longint'(1) << W);
    if (y[W-1]) sy = uy - (longint'(1) << W);
`endif
    r = '0; o = 1'b0; n = 1'b0; multi = 1'b0;
    case (c)
      3'd0: r = {{W{1'b0}}, x};
      3'd1: begin t = sx + sy; r = t[2*W-1:0];
`ifdef ALU_SEQ_SIGNED_EN
        n = r[2*W-1];
`endif
      end
      3'd2: begin
`ifdef ALU_SEQ_SIGNED_EN
        t = sx - sy; r = t[2*W-1:0]; n = r[2*W-1];
`else
        t = (ux >= uy) ? ux - uy : uy - ux; r = t[2*W-1:0]; n = (ux < uy);
`endif
      end
      3'd3: begin multi = 1'b1; t = sx * sy; r = t[2*W-1:0];
`ifdef ALU_SEQ_SIGNED_EN
        n = r[2*W-1];
`endif
      end
      3'd4: begin
        if (uy == 0) o = 1'b1;
`ifdef ALU_SEQ_SIGNED_EN
        else if (sx == -(longint'(1) << (W-1)) && sy == -1) o = 1'b1;
`endif
        else begin
          multi = 1'b1;
          q = sx / sy; rm = sx % sy;
          r = {rm[W-1:0], q[W-1:0]};
`ifdef ALU_SEQ_SIGNED_EN
          n = q[W-1];
`endif
        end
      end
      3'd5: r = {{W{1'b0}}, x & y};
      3'd6: r = {{W{1'b0}}, x | y};
      default: r = {{W{1'b0}}, ~x};
    endcase
    z = (r == '0);
  endfunction

  task automatic drive(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clock);
    start = 1'b1; command_code = c; xdata = x; ydata = y;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Issues one op and waits (bounded) for done; reports observations only.
  task automatic exec(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                      output logic [2*W-1:0] r, output logic [2:0] f, output int lat,
                      output logic bsy_all, output logic bsy_done);
    drive(c, x, y);
    lat = 1; bsy_all = 1'b1;
    while (done !== 1'b1 && lat < 20) begin
      if (busy !== 1'b1) bsy_all = 1'b0;
      @(posedge clock); #1;
      lat++;
    end
    r = result; f = {flagZ, flagO, flagN}; bsy_done = busy;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; command_code = '0; xdata = '0; ydata = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (result !== '0) begin failures++; $display("FAIL reset_result: got %h want 00", result); end
    checks++; if ({flagZ, flagO, flagN} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got %b want 000", {flagZ, flagO, flagN}); end
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_directed;
    logic [2*W-1:0] er, r; logic ez, eo, en, em, ba, bd; logic [2:0] f; int lat;
    for (int i = 0; i < 8; i++) begin
      model(dc[i], dx[i], dy[i], er, ez, eo, en, em);
      exec(dc[i], dx[i], dy[i], r, f, lat, ba, bd);
      checks++; if (r !== er) begin failures++;
        $display("FAIL dir_result[%0d]: got %h want %h", i, r, er); end
      checks++; if (f !== {ez, eo, en}) begin failures++;
        $display("FAIL dir_flags[%0d]: got ZON=%b want %b", i, f, {ez, eo, en}); end
      checks++; if (lat !== (em ? W + 1 : 1)) begin failures++;
        $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, em ? W + 1 : 1); end
      checks++; if (bd !== 1'b0) begin failures++; $display("FAIL dir_busy_at_done[%0d]: got 1 want 0", i); end
      if (em) begin
        checks++; if (ba !== 1'b1) begin failures++; $display("FAIL dir_busy_during[%0d]: got low want high", i); end
      end
      @(posedge clock); #1;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL dir_done_pulse[%0d]: got 1 want 0", i); end
    end
  endtask

  task automatic test_random;
    logic [2*W-1:0] er, r; logic ez, eo, en, em, ba, bd; logic [2:0] f; int lat;
    logic [2:0] c; logic [W-1:0] x, y;
    for (int i = 0; i < 40; i++) begin
      c = 3'($urandom_range(0, 7));
      x = W'($urandom);
      y = W'($urandom);
      if (c == 3'd4 && $urandom_range(0, 3) == 0) y = '0;
      model(c, x, y, er, ez, eo, en, em);
      exec(c, x, y, r, f, lat, ba, bd);
      checks++; if (r !== er) begin failures++;
        $display("FAIL rnd_result op=%0d x=%h y=%h: got %h want %h", c, x, y, r, er); end
      checks++; if (f !== {ez, eo, en}) begin failures++;
        $display("FAIL rnd_flags op=%0d x=%h y=%h: got ZON=%b want %b", c, x, y, f, {ez, eo, en}); end
      checks++; if (lat !== (em ? W + 1 : 1)) begin failures++;
        $display("FAIL rnd_latency op=%0d: got %0d want %0d", c, lat, em ? W + 1 : 1); end
      @(posedge clock); #1;
      checks++; if (done !== 1'b0 || result !== er) begin failures++;
        $display("FAIL rnd_hold op=%0d: got done=%b result=%h want done=0 result=%h", c, done, result, er); end
    end
  endtask

  task automatic test_busy_ignore;
    logic [2*W-1:0] er; logic ez, eo, en, em; int lat;
    model(3'd3, 4'hB, 4'h7, er, ez, eo, en, em);
    drive(3'd3, 4'hB, 4'h7);
    lat = 1;
    @(negedge clock);
    start = 1'b1; command_code = 3'd1; xdata = 4'h2; ydata = 4'h3;
    @(posedge clock); #1;
    start = 1'b0; lat++;
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++;
      $display("FAIL ignore_start: got done=%b busy=%b want done=0 busy=1", done, busy); end
    while (done !== 1'b1 && lat < 20) begin @(posedge clock); #1; lat++; end
    checks++; if (lat !== W + 1) begin failures++; $display("FAIL ignore_latency: got %0d want %0d", lat, W + 1); end
    checks++; if (result !== er) begin failures++; $display("FAIL ignore_result: got %h want %h", result, er); end
    @(posedge clock); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL ignore_extra_done: got 1 want 0"); end
  endtask

  task automatic test_back_to_back;
    logic [2*W-1:0] r; logic [2:0] f; int lat; logic ba, bd;
    exec(3'd1, 4'd6, 4'd7, r, f, lat, ba, bd);
    checks++; if (r !== 8'h0D) begin failures++; $display("FAIL b2b_first: got %h want 0d", r); end
    exec(3'd6, 4'd5, 4'd10, r, f, lat, ba, bd);
    checks++; if (lat !== 1 || r !== 8'h0F) begin failures++;
      $display("FAIL b2b_second: got lat=%0d result=%h want lat=1 result=0f", lat, r); end
    exec(3'd3, 4'd3, 4'd3, r, f, lat, ba, bd);
    checks++; if (lat !== W + 1 || r !== 8'h09) begin failures++;
      $display("FAIL b2b_mul: got lat=%0d result=%h want lat=%0d result=09", lat, r, W + 1); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    drive(3'd3, 4'hF, 4'hF);
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++;
      $display("FAIL midrst_ctrl: got busy=%b done=%b want 0 0", busy, done); end
    checks++; if (result !== '0 || {flagZ, flagO, flagN} !== 3'b000) begin failures++;
      $display("FAIL midrst_data: got result=%h flags=%b want 00 000", result, {flagZ, flagO, flagN}); end
    @(negedge clock); reset = 1'b0;
    seen = 1'b0;
    repeat (W + 3) begin @(posedge clock); #1; if (done === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_no_done: got done pulse want none"); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
